// File: rtl/fir_mac_param.sv
// Serial FIR filter: one multiply-accumulate per cycle over a TAPS-deep delay line,
// with a valid/ready sample input, a held result output and runtime-writable coefficients.
module fir_mac_param #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 19
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic [COEF_W-1:0]          coef_data,
  input  logic                       clear,
  output logic                       busy
);

  localparam int ADDR_W = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state_reg;
  logic signed [DATA_W-1:0]  x_reg [TAPS];
  logic signed [COEF_W-1:0]  c_reg [TAPS];
  logic signed [OUT_W-1:0]   acc_reg;
  logic signed [OUT_W-1:0]   acc_next;
  logic signed [OUT_W-1:0]   out_data_reg;
  logic [ADDR_W-1:0]         idx_reg;
  logic                      out_valid_reg;
  logic                      accept;
  logic                      coef_wr;
  logic signed [PROD_W-1:0]  x_ext;
  logic signed [PROD_W-1:0]  c_ext;
  logic signed [PROD_W-1:0]  prod;

  assign in_ready  = (state_reg == IDLE) && !coef_we;
  assign accept    = in_valid && in_ready && !clear;
  assign coef_wr   = coef_we && (state_reg == IDLE) && !clear;
  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  // A PROD_W-bit signed product can never overflow, so the sum stays exact.
  assign x_ext    = PROD_W'(x_reg[idx_reg]);
  assign c_ext    = PROD_W'(c_reg[idx_reg]);
  assign prod     = x_ext * c_ext;
  assign acc_next = acc_reg + OUT_W'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        x_reg[k] <= '0;
        c_reg[k] <= '0;
      end
    end else begin
      // clear flushes the samples but keeps the loaded coefficient set.
      if (clear) begin
        for (int k = 0; k < TAPS; k++) x_reg[k] <= '0;
      end else if (accept) begin
        for (int k = TAPS - 1; k > 0; k--) x_reg[k] <= x_reg[k-1];
        x_reg[0] <= $signed(in_data);
      end
      if (coef_wr) begin
        for (int k = 0; k < TAPS; k++)
          if (coef_addr == ADDR_W'(k)) c_reg[k] <= $signed(coef_data);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      idx_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else if (clear) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            acc_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= MAC;
          end
        end
        MAC: begin
          acc_reg <= acc_next;
          if (idx_reg == LAST_IDX) begin
            state_reg     <= OUT;
            out_valid_reg <= 1'b1;
            out_data_reg  <= acc_next;
          end else begin
            idx_reg <= idx_reg + ADDR_W'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_param.sv
// Randomized and directed bench for fir_mac_param; a sum-of-products model feeds a
// scoreboard queue that an independent monitor drains on every output handshake.
module tb_fir_mac_param;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 8;
  localparam int OUT_W  = 19;
  localparam int AW     = 3;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              clear;
  logic              busy;

  typedef struct {
    int exp;
    int acyc;
  } exp_t;

  exp_t sb[$];
  int   c_m [TAPS];
  int   x_m [TAPS];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   n_out      = 0;
  bit   rand_bp    = 0;
  bit   prev_v     = 0;

  fir_mac_param #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .clear(clear), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_out();
    int s = 0;
    for (int k = 0; k < TAPS; k++) s += x_m[k] * c_m[k];
    return s;
  endfunction

  task automatic model_accept(input int s);
    for (int k = TAPS - 1; k > 0; k--) x_m[k] = x_m[k-1];
    x_m[0] = s;
    sb.push_back('{exp: model_out(), acyc: cyc + 1});
  endtask

  task automatic model_zero_x();
    for (int k = 0; k < TAPS; k++) x_m[k] = 0;
  endtask

  // Output monitor: latency on each rising out_valid, data on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_output: got out_valid=1 data=%0d, expected no result", $signed(out_data));
        end else begin
          chk("latency", cyc - sb[0].acyc, TAPS);
        end
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        exp_t e;
        int   act;
        e   = sb.pop_front();
        act = $signed(out_data);
        n_out++;
        $display("result %0d: out_data=%0d expected=%0d", n_out, act, e.exp);
        chk("out_data", act, e.exp);
      end
      prev_v = out_valid;
    end
  end

  // All tasks below start and end 1 time unit after a rising edge.
  task automatic send(input int s);
    bit ok = 0;
    in_data  = s[DATA_W-1:0];
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready && !coef_we) begin
        model_accept(s);
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected acceptance");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wr_coef(input int a, input int v, input bit takes_effect);
    coef_we   = 1'b1;
    coef_addr = a[AW-1:0];
    coef_data = v[COEF_W-1:0];
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    if (takes_effect) c_m[a] = v;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 2000; n++) begin
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    model_zero_x();
    for (int k = 0; k < TAPS; k++) c_m[k] = 0;
    sb.delete();
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_data", int'(out_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; clear = 1'b0;
    #1;
    do_rst();

    // Zero coefficients after reset give zero output.
    send(57);
    drain();

    // Impulse response reproduces the coefficient list, then returns to zero.
    for (int k = 0; k < TAPS; k++) wr_coef(k, k + 1, 1);
    send(1);
    for (int k = 0; k < TAPS; k++) send(0);
    drain();

    // Most-negative samples and coefficients.
    for (int k = 0; k < TAPS; k++) wr_coef(k, -128, 1);
    for (int k = 0; k < TAPS; k++) send(-128);
    drain();

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    send(5);
    begin
      bit seen = 0;
      for (int n = 0; n < 50; n++) begin
        @(negedge clk);
        if (out_valid) begin
          seen = 1;
          break;
        end
      end
      chk("bp_out_valid_seen", int'(seen), 1);
      for (int n = 0; n < 5; n++) begin
        if (n > 0) @(negedge clk);
        chk("bp_out_valid", int'(out_valid), 1);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_busy", int'(busy), 1);
        if (sb.size() > 0) chk("bp_out_data", $signed(out_data), sb[0].exp);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_busy", int'(busy), 0);
    chk("bp_release_out_valid", int'(out_valid), 0);

    // Coefficient write and sample offered together: write wins, sample waits one cycle.
    for (int k = 0; k < TAPS; k++) wr_coef(k, 3 * k - 10, 1);
    coef_we = 1'b1; coef_addr = 3'd2; coef_data = 8'd7;
    in_valid = 1'b1; in_data = 8'd3;
    @(negedge clk);
    chk("collide_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    c_m[2] = 7;
    @(negedge clk);
    chk("collide_next_in_ready", int'(in_ready), 1);
    model_accept(3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wr_coef(2, 99, 0);
    send(-4);
    send(6);
    drain();

    // clear during MAC: no result, samples flushed, coefficients kept.
    send(11);
    idle_cycles(3);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_zero_x();
    sb.delete();
    chk("clear_busy", int'(busy), 0);
    chk("clear_out_valid", int'(out_valid), 0);
    idle_cycles(12);
    // clear, coef_we and in_valid together in IDLE: only the clear acts.
    send(21);
    drain();
    clear = 1'b1; coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'd55;
    in_valid = 1'b1; in_data = 8'd100;
    @(posedge clk);
    #1;
    clear = 1'b0; coef_we = 1'b0; in_valid = 1'b0;
    model_zero_x();
    send(9);
    drain();

    // rst during MAC: no result, coefficients cleared too.
    send(13);
    idle_cycles(3);
    do_rst();
    idle_cycles(12);
    send(20);
    send(-77);
    drain();

    // Random coefficients, samples and output backpressure.
    for (int k = 0; k < TAPS; k++) wr_coef(k, int'($urandom_range(0, 255)) - 128, 1);
    rand_bp = 1'b1;
    for (int n = 0; n < 40; n++) send(int'($urandom_range(0, 255)) - 128);
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();
    idle_cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
